tnoc_link_pipeline: RTL and testbench

//  Parametrised inter-router link for next-gen mesh fabric: inserts STAGES register slices on one

---
 rtl/tnoc_link_pipeline.sv | 175 +++++++++++++++++
 tb/tb_tnoc_link_pipeline.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnoc_link_pipeline.sv
// -----------------------------------------------------------------------------
// tnoc_link_pipeline
//   Inter-router link retiming. It inserts STAGES register slices in series on
//   one direction of a link. Each virtual channel has its own chain, so a
//   stalled VC never blocks another VC. Every slice is a 2-entry skid buffer:
//   ready toward the upstream side comes straight from a flop, and valid toward
//   the downstream side is derived only from slice state. As a result there is
//   no combinational path from i_ready to o_ready or from i_valid to o_valid.
//   With STAGES=0 the link is plain wires.
//
// Ports
//   clk, rst        rising-edge clock; synchronous active-high reset
//   i_valid/o_ready upstream handshake, one bit per VC
//   i_flit          upstream flits, VC c at [c*FLIT_WIDTH +: FLIT_WIDTH]
//   o_valid/i_ready downstream handshake, one bit per VC
//   o_flit          downstream flits, same packing
//   o_flit_count    per-VC count of output transfers (saturating)
//   o_stall_count   per-VC count of cycles with o_valid & !i_ready (saturating)
//
// Build option
//   TNOC_LINK_PIPELINE_STAT_EN: when defined, the two counters are present.
//   When undefined, both count ports are tied to zero. The data path is the
//   same either way.
// -----------------------------------------------------------------------------
module tnoc_link_pipeline #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64,
  parameter int STAGES     = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CHANNELS-1:0]            i_valid,
  output logic [CHANNELS-1:0]            o_ready,
  input  logic [CHANNELS*FLIT_WIDTH-1:0] i_flit,
  output logic [CHANNELS-1:0]            o_valid,
  input  logic [CHANNELS-1:0]            i_ready,
  output logic [CHANNELS*FLIT_WIDTH-1:0] o_flit,
  output logic [CHANNELS*CNT_WIDTH-1:0]  o_flit_count,
  output logic [CHANNELS*CNT_WIDTH-1:0]  o_stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } slot_state_e;

  genvar c, s;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_vc
      if (STAGES == 0) begin : g_wire
        assign o_valid[c]                          = i_valid[c];
        assign o_ready[c]                          = i_ready[c];
        assign o_flit[c*FLIT_WIDTH +: FLIT_WIDTH]  = i_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
      end else begin : g_pipe
        // Chain node k sits between slice k-1 and slice k. Node 0 is the
        // upstream port and node STAGES is the downstream port.
        logic [STAGES:0]       vld;
        logic [STAGES:0]       rdy;
        logic [FLIT_WIDTH-1:0] flit [STAGES+1];

        assign vld[0]      = i_valid[c];
        assign flit[0]     = i_flit[c*FLIT_WIDTH +: FLIT_WIDTH];
        assign o_ready[c]  = rdy[0];
        assign o_valid[c]  = vld[STAGES];
        assign rdy[STAGES] = i_ready[c];
        assign o_flit[c*FLIT_WIDTH +: FLIT_WIDTH] = flit[STAGES];

        for (s = 0; s < STAGES; s++) begin : g_slice
          slot_state_e           state_q, state_d;
          logic                  rdy_q, rdy_d;
          logic [FLIT_WIDTH-1:0] head_q, head_d;
          logic [FLIT_WIDTH-1:0] tail_q, tail_d;
          logic                  push, pop;

          assign push = vld[s] & rdy_q;
          assign pop  = (state_q != EMPTY) & rdy[s+1];

          always_comb begin
            state_d = state_q;
            head_d  = head_q;
            tail_d  = tail_q;
            unique case (state_q)
              EMPTY: begin
                if (push) begin
                  state_d = ONE;
                  head_d  = flit[s];
                end
              end
              ONE: begin
                // On push & pop the occupancy stays at one and the incoming
                // flit becomes the new head.
                if (push && pop) begin
                  head_d = flit[s];
                end else if (push) begin
                  state_d = FULL;
                  tail_d  = flit[s];
                end else if (pop) begin
                  state_d = EMPTY;
                end
              end
              FULL: begin
                if (pop) begin
                  state_d = ONE;
                  head_d  = tail_q;
                end
              end
              default: state_d = EMPTY;
            endcase
            // Ready is registered from the next state. This breaks the
            // combinational ready path and still allows a push in the cycle
            // right after a FULL slice drains.
            rdy_d = (state_d != FULL);
          end

          // Slice boundary: flit registers carry no reset; only control resets.
          always_ff @(posedge clk) begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (rst) begin
              state_q <= EMPTY;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= state_d;
              rdy_q   <= rdy_d;
            end
          end

          assign vld[s+1]  = (state_q != EMPTY);
          assign rdy[s]    = rdy_q;
          assign flit[s+1] = head_q;
        end
      end
    end
  endgenerate

`ifdef TNOC_LINK_PIPELINE_STAT_EN
  genvar cs;
  generate
    for (cs = 0; cs < CHANNELS; cs++) begin : g_stat
      logic [CNT_WIDTH-1:0] flit_cnt_q, flit_cnt_d;
      logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

      always_comb begin
        flit_cnt_d  = flit_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (o_valid[cs] && i_ready[cs] && (flit_cnt_q != '1)) begin
          flit_cnt_d = flit_cnt_q + 1'b1;
        end
        if (o_valid[cs] && !i_ready[cs] && (stall_cnt_q != '1)) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          flit_cnt_q  <= '0;
          stall_cnt_q <= '0;
        end else begin
          flit_cnt_q  <= flit_cnt_d;
          stall_cnt_q <= stall_cnt_d;
        end
      end

      assign o_flit_count[cs*CNT_WIDTH +: CNT_WIDTH]  = flit_cnt_q;
      assign o_stall_count[cs*CNT_WIDTH +: CNT_WIDTH] = stall_cnt_q;
    end
  endgenerate
`else
  assign o_flit_count  = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_tnoc_link_pipeline.sv
module tb_tnoc_link_pipeline;

`ifdef TNOC_LINK_PIPELINE_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  localparam int FW  = 16;
  localparam int NFL = 1700;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Directed instance: 2 VCs, 2 stages, 4-bit counters
  logic [1:0]  a_iv, a_ir, a_ov, a_or;
  logic [31:0] a_if, a_of;
  logic [7:0]  a_fc, a_sc;

  tnoc_link_pipeline #(.CHANNELS(2), .FLIT_WIDTH(FW), .STAGES(2), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst),
    .i_valid(a_iv), .o_ready(a_or), .i_flit(a_if),
    .o_valid(a_ov), .i_ready(a_ir), .o_flit(a_of),
    .o_flit_count(a_fc), .o_stall_count(a_sc)
  );

  // Random instances: STAGES 0, 1, 4
  logic [1:0]  b_iv [3];
  logic [1:0]  b_ir [3];
  logic [1:0]  b_ov [3];
  logic [1:0]  b_or [3];
  logic [31:0] b_if [3];
  logic [31:0] b_of [3];
  logic [31:0] b_fc [3];
  logic [31:0] b_sc [3];

  for (genvar k = 0; k < 3; k++) begin : g_b
    tnoc_link_pipeline #(.CHANNELS(2), .FLIT_WIDTH(FW),
                         .STAGES((k == 0) ? 0 : (k == 1) ? 1 : 4), .CNT_WIDTH(16)) u_b (
      .clk(clk), .rst(rst),
      .i_valid(b_iv[k]), .o_ready(b_or[k]), .i_flit(b_if[k]),
      .o_valid(b_ov[k]), .i_ready(b_ir[k]), .o_flit(b_of[k]),
      .o_flit_count(b_fc[k]), .o_stall_count(b_sc[k])
    );
  end

  typedef struct {
    logic [1:0]  iv;
    logic [1:0]  ir;
    logic [15:0] f0;
    logic [15:0] f1;
    logic [1:0]  ov;
    logic [1:0]  orr;
    logic [15:0] of0;
    logic [15:0] of1;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic [1:0] iv, input logic [1:0] ir,
                              input logic [15:0] f0, input logic [15:0] f1,
                              input logic [1:0] ov, input logic [1:0] orr,
                              input logic [15:0] of0, input logic [15:0] of1);
    vec_t v;
    v.iv = iv; v.ir = ir; v.f0 = f0; v.f1 = f1;
    v.ov = ov; v.orr = orr; v.of0 = of0; v.of1 = of1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends one clock cycle after reset release, at the first cycle that samples
  // the flops out of reset.
  task automatic do_reset();
    rst  = 1'b1;
    a_iv = '0;
    a_ir = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_o_valid", 32'(a_ov), 32'h0);
    chk("rst_o_ready", 32'(a_or), 32'h0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  logic [15:0] expq [6][$];
  int  sent [3][2];
  int  got  [3][2];
  bit  acc  [3][2];
  int  out_cnt;
  int  cyc;
  bit  done;
  logic [15:0] e;

  initial begin
    a_iv = '0; a_ir = '0; a_if = '0;
    for (int k = 0; k < 3; k++) begin
      b_iv[k] = '0; b_ir[k] = '0; b_if[k] = '0;
    end

    // Single flit on VC0, then backpressure on VC0 with VC1 streaming
    tbl[0]  = mk(2'b01, 2'b11, 16'hA5, 16'h00, 2'b00, 2'b11, 16'h00, 16'h00);
    tbl[1]  = mk(2'b00, 2'b11, 16'h00, 16'h00, 2'b00, 2'b11, 16'h00, 16'h00);
    tbl[2]  = mk(2'b00, 2'b11, 16'h00, 16'h00, 2'b01, 2'b11, 16'hA5, 16'h00);
    tbl[3]  = mk(2'b00, 2'b11, 16'h00, 16'h00, 2'b00, 2'b11, 16'h00, 16'h00);
    tbl[4]  = mk(2'b11, 2'b10, 16'h10, 16'h20, 2'b00, 2'b11, 16'h00, 16'h00);
    tbl[5]  = mk(2'b11, 2'b10, 16'h11, 16'h21, 2'b00, 2'b11, 16'h00, 16'h00);
    tbl[6]  = mk(2'b11, 2'b10, 16'h12, 16'h22, 2'b11, 2'b11, 16'h10, 16'h20);
    tbl[7]  = mk(2'b11, 2'b10, 16'h13, 16'h23, 2'b11, 2'b11, 16'h10, 16'h21);
    tbl[8]  = mk(2'b11, 2'b10, 16'h14, 16'h24, 2'b11, 2'b10, 16'h10, 16'h22);
    tbl[9]  = mk(2'b11, 2'b10, 16'h14, 16'h25, 2'b11, 2'b10, 16'h10, 16'h23);
    tbl[10] = mk(2'b11, 2'b11, 16'h14, 16'h26, 2'b11, 2'b10, 16'h10, 16'h24);
    tbl[11] = mk(2'b11, 2'b11, 16'h14, 16'h27, 2'b11, 2'b10, 16'h11, 16'h25);
    tbl[12] = mk(2'b11, 2'b11, 16'h14, 16'h28, 2'b11, 2'b11, 16'h12, 16'h26);
    tbl[13] = mk(2'b10, 2'b11, 16'h00, 16'h29, 2'b11, 2'b11, 16'h13, 16'h27);
    tbl[14] = mk(2'b00, 2'b11, 16'h00, 16'h00, 2'b11, 2'b11, 16'h14, 16'h28);
    tbl[15] = mk(2'b00, 2'b11, 16'h00, 16'h00, 2'b10, 2'b11, 16'h00, 16'h29);
    tbl[16] = mk(2'b00, 2'b11, 16'h00, 16'h00, 2'b00, 2'b11, 16'h00, 16'h00);

    tick();
    do_reset();

    for (int i = 0; i < 17; i++) begin
      a_iv = tbl[i].iv;
      a_ir = tbl[i].ir;
      a_if = {tbl[i].f1, tbl[i].f0};
      @(negedge clk);
      chk($sformatf("tbl%0d_o_valid", i), 32'(a_ov), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_o_ready", i), 32'(a_or), 32'(tbl[i].orr));
      if (tbl[i].ov[0]) chk($sformatf("tbl%0d_flit0", i), 32'(a_of[15:0]), 32'(tbl[i].of0));
      if (tbl[i].ov[1]) chk($sformatf("tbl%0d_flit1", i), 32'(a_of[31:16]), 32'(tbl[i].of1));
      tick();
    end

    // 100 incrementing flits on VC1, downstream always ready
    out_cnt = 0;
    for (int n = 0; n < 104; n++) begin
      a_ir = 2'b11;
      a_iv = {(n < 100), 1'b0};
      a_if = {16'(n), 16'h0};
      @(negedge clk);
      chk("stream_o_ready1", 32'(a_or[1]), 32'h1);
      chk("stream_o_valid", 32'(a_ov), {30'h0, (n >= 2 && n < 102), 1'b0});
      if (a_ov[1]) begin
        chk("stream_flit", 32'(a_of[31:16]), 32'(n - 2));
        out_cnt++;
      end
      tick();
    end
    chk("stream_count", 32'(out_cnt), 32'd100);

    // Reset with three flits buffered on VC0
    a_iv = 2'b00;
    a_ir = 2'b00;
    for (int n = 0; n < 3; n++) begin
      a_iv = 2'b01;
      a_if = {16'h0, 16'(16'h51 + n)};
      tick();
    end
    a_iv = 2'b00;
    @(negedge clk);
    chk("pre_rst_buffered", 32'(a_ov[0]), 32'h1);
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("mid_rst_o_valid", 32'(a_ov), 32'h0);
    chk("mid_rst_o_ready", 32'(a_or), 32'h0);
    tick();
    rst  = 1'b0;
    a_ir = 2'b11;
    tick();
    @(negedge clk);
    chk("post_rst_o_ready", 32'(a_or), 32'h3);
    for (int n = 0; n < 8; n++) begin
      chk("post_rst_no_stale", 32'(a_ov), 32'h0);
      tick();
      @(negedge clk);
    end
    tick();

    // Statistics: 20 transfers then 3 stall cycles on VC0
    do_reset();
    a_ir = 2'b11;
    for (int n = 0; n < 23; n++) begin
      a_iv = {1'b0, (n < 20)};
      a_if = {16'h0, 16'(16'h100 + n)};
      tick();
    end
    @(negedge clk);
    chk("flit_count_sat", 32'(a_fc), STAT ? 32'h0F : 32'h0);
    chk("stall_count_zero", 32'(a_sc), 32'h0);
    tick();
    a_ir = 2'b00;
    a_iv = 2'b01;
    a_if = {16'h0, 16'h0BEE};
    tick();
    a_iv = 2'b00;
    tick();
    @(negedge clk);
    chk("stall_valid", 32'(a_ov[0]), 32'h1);
    tick();
    tick();
    tick();
    a_ir = 2'b11;
    @(negedge clk);
    chk("stall_count", 32'(a_sc), STAT ? 32'h03 : 32'h0);
    chk("stall_flit", 32'(a_of[15:0]), 32'h0BEE);
    tick();
    @(negedge clk);
    chk("flit_count_hold", 32'(a_fc), STAT ? 32'h0F : 32'h0);
    tick();

    // Random valid/ready on STAGES 0/1/4, FIFO scoreboard per VC
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++) begin
        sent[k][c] = 0; got[k][c] = 0; acc[k][c] = 1'b0;
      end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40000) begin
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 2; c++) begin
          if (acc[k][c]) b_iv[k][c] = 1'b0;
          acc[k][c] = 1'b0;
          if (!b_iv[k][c] && sent[k][c] < NFL && $urandom_range(1, 0) == 1) begin
            b_iv[k][c] = 1'b1;
            b_if[k][c*FW +: FW] = {c[0], 2'(k), 13'(sent[k][c])};
          end
          b_ir[k][c] = 1'($urandom_range(1, 0));
        end
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 2; c++) begin
          if (b_iv[k][c] && b_or[k][c]) begin
            expq[k*2+c].push_back(b_if[k][c*FW +: FW]);
            sent[k][c]++;
            acc[k][c] = 1'b1;
          end
          if (b_ov[k][c] && b_ir[k][c]) begin
            if (expq[k*2+c].size() == 0) begin
              chk($sformatf("rnd_dup_k%0d_c%0d", k, c), 32'(b_of[k][c*FW +: FW]), 32'hFFFFFFFF);
            end else begin
              e = expq[k*2+c].pop_front();
              chk($sformatf("rnd_flit_k%0d_c%0d", k, c), 32'(b_of[k][c*FW +: FW]), 32'(e));
            end
            got[k][c]++;
          end
        end
      done = 1'b1;
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 2; c++)
          if (got[k][c] < NFL) done = 1'b0;
      cyc++;
      tick();
    end
    chk("rnd_finished", 32'(done), 32'h1);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("rnd_got_k%0d_c%0d", k, c), 32'(got[k][c]), 32'(NFL));
        chk($sformatf("rnd_left_k%0d_c%0d", k, c), 32'(expq[k*2+c].size()), 32'h0);
      end
    for (int k = 0; k < 3; k++) b_iv[k] = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
